// File: rtl/sound_mix_sequencer.sv
// Three-channel sound mixer for an MSX-style bus: write-only volume/control
// registers plus a six-state sequencer that mixes one sample per sample_en.
module sound_mix_sequencer #(
  parameter logic [7:0] IO_BASE = 8'hB4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        sample_en,
  input  logic        n_ioreq,
  input  logic        n_wr,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic [7:0]  ssg_in,
  input  logic [10:0] scc_in,
  input  logic [15:0] opll_in,
  output logic [16:0] mix_out,
  output logic        mix_valid,
  output logic        overrun
);

  // Handshake: sample_en is a one-cycle request taken only in IDLE; mix_valid
  // is a one-cycle pulse with mix_out valid in the same cycle (no back-pressure).
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACC_SSG  = 3'd1,
    ACC_SCC  = 3'd2,
    ACC_OPLL = 3'd3,
    SAT      = 3'd4,
    OUT      = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic ioreq_meta_q, ioreq_meta_d, ioreq_sync_q, ioreq_sync_d;
  logic wr_meta_q, wr_meta_d, wr_sync_q, wr_sync_d;
  logic strobe_prev_q, strobe_prev_d;

  logic [7:0] vol_ssg_q, vol_ssg_d, vol_scc_q, vol_scc_d, vol_opll_q, vol_opll_d;
  logic       mute_q, mute_d;

  logic [7:0]  ssg_snap_q, ssg_snap_d;
  logic [10:0] scc_snap_q, scc_snap_d;
  logic [15:0] opll_snap_q, opll_snap_d;
  logic [7:0]  vs_snap_q, vs_snap_d, vc_snap_q, vc_snap_d, vo_snap_q, vo_snap_d;
  logic        mute_snap_q, mute_snap_d;

  logic signed [27:0] acc_q, acc_d;
  logic [16:0]        sat_q, sat_d;
  logic [16:0]        mix_out_q, mix_out_d;
  logic               mix_valid_q, mix_valid_d;
  logic               overrun_q, overrun_d;

  logic               strobe, wr_evt, hit, ovr_clr, ovr_set;
  logic signed [16:0] mul_a;
  logic signed [8:0]  mul_b;
  logic signed [25:0] product;
  logic signed [27:0] prod_ext;
  logic signed [27:0] acc_shr;
  logic [16:0]        sat_val;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^address[15:8];

  assign strobe  = ioreq_sync_q | wr_sync_q;
  assign wr_evt  = strobe_prev_q & ~strobe;
  assign hit     = (address[7:2] == IO_BASE[7:2]);
  assign ovr_clr = wr_evt & hit & (address[1:0] == 2'd3) & wdata[7];
  assign ovr_set = sample_en & (state_q != IDLE);

  // One multiplier, its operands steered by the accumulate state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      ACC_SSG: begin
        mul_a = $signed({{4{ssg_snap_q[7]}}, ssg_snap_q, 5'b0});
        mul_b = $signed({1'b0, vs_snap_q});
      end
      ACC_SCC: begin
        mul_a = $signed({scc_snap_q[10], scc_snap_q, 5'b0});
        mul_b = $signed({1'b0, vc_snap_q});
      end
      ACC_OPLL: begin
        mul_a = $signed({opll_snap_q[15], opll_snap_q});
        mul_b = $signed({1'b0, vo_snap_q});
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign product  = mul_a * mul_b;
  assign prod_ext = $signed({{2{product[25]}}, product});
  assign acc_shr  = acc_q >>> 7;

  always_comb begin
    if (acc_shr > 28'sd65535) begin
      sat_val = 17'h0FFFF;
    end else if (acc_shr < -28'sd65536) begin
      sat_val = 17'h10000;
    end else begin
      sat_val = acc_shr[16:0];
    end
  end

  always_comb begin
    ioreq_meta_d  = n_ioreq;
    ioreq_sync_d  = ioreq_meta_q;
    wr_meta_d     = n_wr;
    wr_sync_d     = wr_meta_q;
    strobe_prev_d = strobe;

    vol_ssg_d  = vol_ssg_q;
    vol_scc_d  = vol_scc_q;
    vol_opll_d = vol_opll_q;
    mute_d     = mute_q;

    state_d     = state_q;
    ssg_snap_d  = ssg_snap_q;
    scc_snap_d  = scc_snap_q;
    opll_snap_d = opll_snap_q;
    vs_snap_d   = vs_snap_q;
    vc_snap_d   = vc_snap_q;
    vo_snap_d   = vo_snap_q;
    mute_snap_d = mute_snap_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;

    if (wr_evt && hit) begin
      case (address[1:0])
        2'd0:    vol_ssg_d  = wdata;
        2'd1:    vol_scc_d  = wdata;
        2'd2:    vol_opll_d = wdata;
        default: mute_d     = wdata[0];
      endcase
    end

    // Snapshot reads the _q registers, so a same-cycle write lands next sample.
    case (state_q)
      IDLE: begin
        if (sample_en) begin
          state_d     = ACC_SSG;
          ssg_snap_d  = ssg_in;
          scc_snap_d  = scc_in;
          opll_snap_d = opll_in;
          vs_snap_d   = vol_ssg_q;
          vc_snap_d   = vol_scc_q;
          vo_snap_d   = vol_opll_q;
          mute_snap_d = mute_q;
          acc_d       = '0;
        end
      end
      ACC_SSG: begin
        acc_d   = acc_q + prod_ext;
        state_d = ACC_SCC;
      end
      ACC_SCC: begin
        acc_d   = acc_q + prod_ext;
        state_d = ACC_OPLL;
      end
      ACC_OPLL: begin
        acc_d   = acc_q + prod_ext;
        state_d = SAT;
      end
      SAT: begin
        sat_d   = mute_snap_q ? 17'd0 : sat_val;
        state_d = OUT;
      end
      OUT: begin
        mix_out_d   = sat_q;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (ovr_set) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ioreq_meta_q  <= 1'b1;
      ioreq_sync_q  <= 1'b1;
      wr_meta_q     <= 1'b1;
      wr_sync_q     <= 1'b1;
      strobe_prev_q <= 1'b1;
      vol_ssg_q     <= 8'd128;
      vol_scc_q     <= 8'd128;
      vol_opll_q    <= 8'd128;
      mute_q        <= 1'b0;
      state_q       <= IDLE;
      ssg_snap_q    <= '0;
      scc_snap_q    <= '0;
      opll_snap_q   <= '0;
      vs_snap_q     <= '0;
      vc_snap_q     <= '0;
      vo_snap_q     <= '0;
      mute_snap_q   <= 1'b0;
      acc_q         <= '0;
      sat_q         <= '0;
      mix_out_q     <= '0;
      mix_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      ioreq_meta_q  <= ioreq_meta_d;
      ioreq_sync_q  <= ioreq_sync_d;
      wr_meta_q     <= wr_meta_d;
      wr_sync_q     <= wr_sync_d;
      strobe_prev_q <= strobe_prev_d;
      vol_ssg_q     <= vol_ssg_d;
      vol_scc_q     <= vol_scc_d;
      vol_opll_q    <= vol_opll_d;
      mute_q        <= mute_d;
      state_q       <= state_d;
      ssg_snap_q    <= ssg_snap_d;
      scc_snap_q    <= scc_snap_d;
      opll_snap_q   <= opll_snap_d;
      vs_snap_q     <= vs_snap_d;
      vc_snap_q     <= vc_snap_d;
      vo_snap_q     <= vo_snap_d;
      mute_snap_q   <= mute_snap_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      mix_out_q     <= mix_out_d;
      mix_valid_q   <= mix_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sound_mix_sequencer.sv
// Bench for sound_mix_sequencer: fixed vector table, hand-written corner
// sequences, then random samples scored against an arithmetic mixing model.
module tb_sound_mix_sequencer;

  localparam logic [7:0] BASE = 8'hB4;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        sample_en = 1'b0;
  logic        n_ioreq = 1'b1;
  logic        n_wr = 1'b1;
  logic [15:0] address = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  ssg_in = '0;
  logic [10:0] scc_in = '0;
  logic [15:0] opll_in = '0;
  logic [16:0] mix_out;
  logic        mix_valid;
  logic        overrun;

  int vec_count = 0;
  int miscompares = 0;
  int cur_vol[3];
  bit cur_mute;

  typedef struct {
    logic [7:0]  ssg;
    logic [10:0] scc;
    logic [15:0] opll;
    logic [7:0]  v0, v1, v2;
    logic        mute;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[7];

  sound_mix_sequencer #(.IO_BASE(BASE)) dut (
    .clk(clk), .n_reset(n_reset), .sample_en(sample_en), .n_ioreq(n_ioreq),
    .n_wr(n_wr), .address(address), .wdata(wdata), .ssg_in(ssg_in),
    .scc_in(scc_in), .opll_in(opll_in), .mix_out(mix_out),
    .mix_valid(mix_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    vec_count++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [7:0] s, input logic [10:0] c,
                                        input logic [15:0] o, input int v0, input int v1,
                                        input int v2, input bit mute);
    longint sum, q;
    sum = longint'($signed(s)) * 32 * v0 + longint'($signed(c)) * 32 * v1
        + longint'($signed(o)) * v2;
    q = sum >>> 7;
    if (q > 65535) q = 65535;
    if (q < -65536) q = -65536;
    if (mute) q = 0;
    return q[16:0];
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; wdata = d; n_ioreq = 1'b0; n_wr = 1'b0;
    repeat (4) @(negedge clk);
    n_ioreq = 1'b1; n_wr = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_result(output int lat, output int pulses, output logic [16:0] got);
    lat = -1; pulses = 0; got = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mix_valid) begin
        pulses++;
        if (lat < 0) begin lat = i; got = mix_out; end
      end
    end
  endtask

  task automatic do_sample(input logic [7:0] s, input logic [10:0] c,
                           input logic [15:0] o, input logic [16:0] exp, input string nm);
    int lat, pulses;
    logic [16:0] got;
    @(negedge clk);
    ssg_in = s; scc_in = c; opll_in = o; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    ssg_in = 8'($urandom); scc_in = 11'($urandom); opll_in = 16'($urandom);
    wait_result(lat, pulses, got);
    check({nm, " latency"}, lat, 5);
    check({nm, " pulses"}, pulses, 1);
    check({nm, " mix_out"}, got, exp);
    check({nm, " hold"}, mix_out, exp);
  endtask

  task automatic set_regs(input int v0, input int v1, input int v2, input bit m);
    if (v0 != cur_vol[0]) bus_write({8'h00, BASE}, 8'(v0));
    if (v1 != cur_vol[1]) bus_write({8'h00, BASE + 8'd1}, 8'(v1));
    if (v2 != cur_vol[2]) bus_write({8'h00, BASE + 8'd2}, 8'(v2));
    if (m != cur_mute) bus_write({8'h00, BASE + 8'd3}, {7'd0, m});
    cur_vol[0] = v0; cur_vol[1] = v1; cur_vol[2] = v2; cur_mute = m;
  endtask

  initial begin
    int lat, pulses;
    logic [16:0] got;
    logic [7:0] rs;
    logic [10:0] rc;
    logic [15:0] ro;

    vecs[0] = '{8'h10, 11'h010, 16'h0100, 8'd128, 8'd128, 8'd128, 1'b0, 17'd1280};
    vecs[1] = '{8'h7F, 11'h3FF, 16'h7FFF, 8'd255, 8'd255, 8'd255, 1'b0, 17'h0FFFF};
    vecs[2] = '{8'h80, 11'h400, 16'h8000, 8'd128, 8'd128, 8'd128, 1'b0, 17'h10000};
    vecs[3] = '{8'h10, 11'h010, 16'h0100, 8'd128, 8'd128, 8'd128, 1'b1, 17'd0};
    vecs[4] = '{8'h10, 11'h010, 16'h0100, 8'd128, 8'd128, 8'd128, 1'b0, 17'd1280};
    vecs[5] = '{8'h00, 11'h000, 16'h0100, 8'd128, 8'd128, 8'd0,   1'b0, 17'd0};
    vecs[6] = '{8'hFF, 11'h7FF, 16'hFFFF, 8'd128, 8'd128, 8'd128, 1'b0, 17'h1FFBF};
    cur_vol[0] = 128; cur_vol[1] = 128; cur_vol[2] = 128; cur_mute = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset mix_out", mix_out, 0);
    check("reset mix_valid", mix_valid, 0);
    check("reset overrun", overrun, 0);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      set_regs(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].mute);
      do_sample(vecs[i].ssg, vecs[i].scc, vecs[i].opll, vecs[i].exp, $sformatf("vec%0d", i));
    end
    set_regs(128, 128, 128, 1'b0);

    // Address decode: other base ignored, upper address byte ignored
    bus_write(16'h00A4, 8'h00);
    do_sample(8'h10, 11'h000, 16'h0000, 17'd512, "decode_other_base");
    bus_write({8'hFF, BASE}, 8'd64);
    cur_vol[0] = 64;
    do_sample(8'h10, 11'h000, 16'h0000, 17'd256, "decode_upper_byte");

    // vol_opll write in the same cycle as sample_en
    @(negedge clk);
    ssg_in = 8'h00; scc_in = 11'h000; opll_in = 16'h0100;
    address = {8'h00, BASE + 8'd2}; wdata = 8'd0; n_ioreq = 1'b0; n_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; n_ioreq = 1'b1; n_wr = 1'b1;
    wait_result(lat, pulses, got);
    check("coincide latency", lat, 5);
    check("coincide old vol", got, 256);
    cur_vol[2] = 0;
    do_sample(8'h00, 11'h000, 16'h0100, 17'd0, "coincide next");

    // Dropped sample_en sets overrun; control bit7 clears it
    @(negedge clk);
    ssg_in = 8'h10; scc_in = 11'h010; opll_in = 16'h0100; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    wait_result(lat, pulses, got);
    check("drop pulses", pulses, 1);
    check("drop latency", lat, 2);
    check("drop mix_out", got, model(8'h10, 11'h010, 16'h0100, 64, 128, 0, 0));
    check("overrun set", overrun, 1);
    bus_write({8'h00, BASE + 8'd3}, 8'h80);
    check("overrun clear", overrun, 0);

    // Overrun set and clear in the same cycle: set wins
    @(negedge clk);
    address = {8'h00, BASE + 8'd3}; wdata = 8'h80; n_ioreq = 1'b0; n_wr = 1'b0;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; n_ioreq = 1'b1; n_wr = 1'b1;
    wait_result(lat, pulses, got);
    check("setclr pulses", pulses, 1);
    check("setclr overrun", overrun, 1);

    // Reset in the middle of a sequence
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("midreset mix_out", mix_out, 0);
    check("midreset overrun", overrun, 0);
    check("midreset mix_valid", mix_valid, 0);
    @(negedge clk);
    #2 n_reset = 1'b1;
    wait_result(lat, pulses, got);
    check("midreset no pulse", pulses, 0);
    cur_vol[0] = 128; cur_vol[1] = 128; cur_vol[2] = 128; cur_mute = 1'b0;
    do_sample(8'h10, 11'h010, 16'h0100, 17'd1280, "after reset");

    // Random samples against the model
    for (int n = 0; n < 24; n++) begin
      int v0, v1, v2;
      bit m;
      v0 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : cur_vol[0];
      v1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : cur_vol[1];
      v2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : cur_vol[2];
      m  = ($urandom_range(0, 7) == 0) ? ~cur_mute : cur_mute;
      set_regs(v0, v1, v2, m);
      rs = 8'($urandom); rc = 11'($urandom); ro = 16'($urandom);
      do_sample(rs, rc, ro, model(rs, rc, ro, v0, v1, v2, m), $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
